// File: rtl/lc3_pkg.sv
// LC3 decode-stage shared definitions:
// opcodes, control-field codes and positions.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] W_ALU   = 2'b00;
  localparam logic [1:0] W_MEM   = 2'b01;
  localparam logic [1:0] W_PCREL = 2'b10;

  localparam int E_ALU_LO = 4;
  localparam int E_PC1_LO = 2;
  localparam int E_PC2    = 1;
  localparam int E_OP2    = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_OFF11 = 2'b00;
  localparam logic [1:0] PC1_OFF9  = 2'b01;
  localparam logic [1:0] PC1_OFF6  = 2'b10;
  localparam logic [1:0] PC1_ZERO  = 2'b11;

  localparam int M_STORE = 1;
  localparam int M_IND   = 0;

  typedef struct packed {
    logic [1:0] w;
    logic [5:0] e;
    logic [1:0] m;
    logic       wb_en;
    logic       illegal;
  } ctrl_t;

  function automatic logic [5:0] e_pack(
    input logic [1:0] alu,
    input logic [1:0] pc1,
    input logic       pc2,
    input logic       op2
  );
    logic [5:0] e;
    e = '0;
    e[E_ALU_LO +: 2] = alu;
    e[E_PC1_LO +: 2] = pc1;
    e[E_PC2]         = pc2;
    e[E_OP2]         = op2;
    return e;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// LC3 control decoder: instruction word in,
// writeback/execute/memory controls out.
module decode_ctrl
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  w,
  output logic [5:0]  e,
  output logic [1:0]  m,
  output logic        wb_en,
  output logic        illegal
);

  logic [3:0] op;
  logic       imm;
  logic       unused_bits;

  assign op  = ir[15:12];
  assign imm = ir[5];
  assign unused_bits = ^{ir[11:6], ir[4:0]};

  // Opcode to control-set lookup; unsupported ops flag illegal
  always_comb begin
    w       = W_ALU;
    e       = '0;
    m       = '0;
    wb_en   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        e     = e_pack(ALU_ADD, PC1_OFF11, 1'b0, !imm);
        wb_en = 1'b1;
      end
      (op == OP_AND): begin
        e     = e_pack(ALU_AND, PC1_OFF11, 1'b0, !imm);
        wb_en = 1'b1;
      end
      (op == OP_NOT): begin
        e     = e_pack(ALU_NOT, PC1_OFF11, 1'b0, 1'b0);
        wb_en = 1'b1;
      end
      (op == OP_LD): begin
        w     = W_MEM;
        e     = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        wb_en = 1'b1;
      end
      (op == OP_LDR): begin
        w     = W_MEM;
        e     = e_pack(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
        wb_en = 1'b1;
      end
      (op == OP_LDI): begin
        w        = W_MEM;
        e        = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        m[M_IND] = 1'b1;
        wb_en    = 1'b1;
      end
      (op == OP_LEA): begin
        w     = W_PCREL;
        e     = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        wb_en = 1'b1;
      end
      (op == OP_ST): begin
        e          = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        m[M_STORE] = 1'b1;
      end
      (op == OP_STR): begin
        e          = e_pack(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
        m[M_STORE] = 1'b1;
      end
      (op == OP_STI): begin
        e          = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        m[M_STORE] = 1'b1;
        m[M_IND]   = 1'b1;
      end
      (op == OP_BR): begin
        e = e_pack(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
      end
      (op == OP_JMP): begin
        e = e_pack(ALU_ADD, PC1_ZERO, 1'b0, 1'b0);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// LC3 decode stage: decode at enqueue, buffer in
// a DEPTH-entry valid/ready FIFO toward execute.
module decode_queue
  import lc3_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     Imem_dout,
  input  logic [PC_W-1:0] npc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     IR,
  output logic [PC_W-1:0] npc_out,
  output logic [1:0]      W_Control,
  output logic [5:0]      E_Control,
  output logic [1:0]      M_Control,
  output logic            wb_en,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     ir_mem  [DEPTH];
  logic [PC_W-1:0] npc_mem [DEPTH];
  ctrl_t           ctrl_mem[DEPTH];
  ctrl_t           dec;
  ctrl_t           head;
  logic            push;
  logic            pop;

  decode_ctrl u_dec (
    .ir      (Imem_dout),
    .w       (dec.w),
    .e       (dec.e),
    .m       (dec.m),
    .wb_en   (dec.wb_en),
    .illegal (dec.illegal)
  );

  assign in_ready  = rst && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = ctrl_mem[rd_ptr];
  assign IR        = ir_mem[rd_ptr];
  assign npc_out   = npc_mem[rd_ptr];
  assign W_Control = head.w;
  assign E_Control = head.e;
  assign M_Control = head.m;
  assign wb_en     = head.wb_en;
  assign illegal   = head.illegal;

  // Queue storage, pointers and occupancy; flush wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ir_mem[k]   <= '0;
        npc_mem[k]  <= '0;
        ctrl_mem[k] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ir_mem[wr_ptr]   <= Imem_dout;
        npc_mem[wr_ptr]  <= npc_in;
        ctrl_mem[wr_ptr] <= dec;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode
// table vectors, corner sequences, random model.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Imem_dout;
  logic [15:0] npc_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [1:0]  W_Control;
  logic [5:0]  E_Control;
  logic [1:0]  M_Control;
  logic        wb_en;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decode_queue #(.DEPTH(DEPTH), .PC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Imem_dout (Imem_dout),
    .npc_in    (npc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .IR        (IR),
    .npc_out   (npc_out),
    .W_Control (W_Control),
    .E_Control (E_Control),
    .M_Control (M_Control),
    .wb_en     (wb_en),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
  } item_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [1:0]  w;
    logic [5:0]  e;
    logic [1:0]  m;
    logic        wb;
    logic        ill;
  } vec_t;

  item_t mq[$];
  vec_t  vt[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference decode, written from the opcode table
  function automatic logic [11:0] ref_dec(input logic [15:0] ir);
    logic [1:0] w;
    logic [5:0] e;
    logic [1:0] m;
    logic       wb;
    logic       ill;
    w = 2'b00; e = 6'b0; m = 2'b00; wb = 1'b0; ill = 1'b0;
    case (ir[15:12])
      4'b0001: begin e = ir[5] ? 6'b000000 : 6'b000001; wb = 1; end
      4'b0101: begin e = ir[5] ? 6'b010000 : 6'b010001; wb = 1; end
      4'b1001: begin e = 6'b100000; wb = 1; end
      4'b0010: begin w = 2'b01; e = 6'b000110; wb = 1; end
      4'b0110: begin w = 2'b01; e = 6'b001000; wb = 1; end
      4'b1010: begin w = 2'b01; e = 6'b000110; m = 2'b01; wb = 1; end
      4'b1110: begin w = 2'b10; e = 6'b000110; wb = 1; end
      4'b0011: begin e = 6'b000110; m = 2'b10; end
      4'b0111: begin e = 6'b001000; m = 2'b10; end
      4'b1011: begin e = 6'b000110; m = 2'b11; end
      4'b0000: e = 6'b000110;
      4'b1100: e = 6'b001100;
      default: ill = 1'b1;
    endcase
    return {w, e, m, wb, ill};
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {W_Control, E_Control, M_Control, wb_en, illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare against model, apply one cycle of stimulus
  task automatic cyc(input logic iv, input logic [15:0] ins,
                     input logic [15:0] npc, input logic ordy,
                     input logic fl);
    bit pu;
    bit po;
    item_t it;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk("head_ir", 32'(IR), 32'(mq[0].ir));
      chk("head_npc", 32'(npc_out), 32'(mq[0].npc));
      chk("head_ctrl", 32'(dut_ctrl()), 32'(ref_dec(mq[0].ir)));
    end
    in_valid  = iv;
    Imem_dout = ins;
    npc_in    = npc;
    out_ready = ordy;
    flush     = fl;
    pu = iv && (mq.size() < DEPTH);
    po = ordy && (mq.size() != 0);
    if (fl) begin
      mq.delete();
    end else begin
      if (po) void'(mq.pop_front());
      if (pu) begin
        it.ir  = ins;
        it.npc = npc;
        mq.push_back(it);
      end
    end
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_IR"}, 32'(IR), 32'd0);
    chk({tag, "_npc"}, 32'(npc_out), 32'd0);
    chk({tag, "_ctrl"}, 32'(dut_ctrl()), 32'd0);
  endtask

  initial begin
    vt[0]  = '{16'h1283, 16'h3001, 2'b00, 6'b000001, 2'b00, 1'b1, 1'b0};
    vt[1]  = '{16'h1021, 16'h3002, 2'b00, 6'b000000, 2'b00, 1'b1, 1'b0};
    vt[2]  = '{16'h5283, 16'h3003, 2'b00, 6'b010001, 2'b00, 1'b1, 1'b0};
    vt[3]  = '{16'h5021, 16'h3004, 2'b00, 6'b010000, 2'b00, 1'b1, 1'b0};
    vt[4]  = '{16'h927F, 16'h3005, 2'b00, 6'b100000, 2'b00, 1'b1, 1'b0};
    vt[5]  = '{16'h2005, 16'h3006, 2'b01, 6'b000110, 2'b00, 1'b1, 1'b0};
    vt[6]  = '{16'h6442, 16'h3007, 2'b01, 6'b001000, 2'b00, 1'b1, 1'b0};
    vt[7]  = '{16'hA405, 16'h3008, 2'b01, 6'b000110, 2'b01, 1'b1, 1'b0};
    vt[8]  = '{16'hE005, 16'h3009, 2'b10, 6'b000110, 2'b00, 1'b1, 1'b0};
    vt[9]  = '{16'h3005, 16'h300A, 2'b00, 6'b000110, 2'b10, 1'b0, 1'b0};
    vt[10] = '{16'h7442, 16'h300B, 2'b00, 6'b001000, 2'b10, 1'b0, 1'b0};
    vt[11] = '{16'hB805, 16'h300C, 2'b00, 6'b000110, 2'b11, 1'b0, 1'b0};
    vt[12] = '{16'h0E05, 16'h300D, 2'b00, 6'b000110, 2'b00, 1'b0, 1'b0};
    vt[13] = '{16'hC1C0, 16'h300E, 2'b00, 6'b001100, 2'b00, 1'b0, 1'b0};
    vt[14] = '{16'h4800, 16'h300F, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};
    vt[15] = '{16'h8000, 16'h3010, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};
    vt[16] = '{16'hD000, 16'h3011, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};
    vt[17] = '{16'hF025, 16'h3012, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; Imem_dout = '0; npc_in = '0;
    #2;
    chk_zero("reset");
    step();
    rst = 1'b1;
    step();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Decode table: push into empty queue, check next cycle, pop
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, vt[i].ir, vt[i].npc, 1'b0, 1'b0);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_ir", 32'(IR), 32'(vt[i].ir));
      chk("vec_npc", 32'(npc_out), 32'(vt[i].npc));
      chk("vec_ctrl", 32'(dut_ctrl()),
          32'({vt[i].w, vt[i].e, vt[i].m, vt[i].wb, vt[i].ill}));
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("vec_drained", 32'(out_valid), 32'd0);

    // Back-to-back stream, one entry per cycle
    begin
      logic [15:0] s_ir[4];
      logic [9:0]  s_ex[4];
      s_ir[0] = 16'hA405; s_ex[0] = 10'b01_000110_01;
      s_ir[1] = 16'hB805; s_ex[1] = 10'b00_000110_11;
      s_ir[2] = 16'hC1C0; s_ex[2] = 10'b00_001100_00;
      s_ir[3] = 16'h6442; s_ex[3] = 10'b01_001000_00;
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, s_ir[i], 16'h3100 + 16'(i), 1'b1, 1'b0);
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_ir", 32'(IR), 32'(s_ir[i]));
        chk("stream_ctrl", 32'({W_Control, E_Control, M_Control}),
            32'(s_ex[i]));
      end
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end

    // Fill to full with no pop, hold, single pop, wrap
    for (int k = 0; k < DEPTH; k++)
      cyc(1'b1, 16'h1040 + 16'(k), 16'h4000 + 16'(k), 1'b0, 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(npc_out), 32'h4000);
    cyc(1'b1, 16'h5555, 16'h4444, 1'b0, 1'b0);
    cyc(1'b1, 16'h5556, 16'h4445, 1'b1, 1'b0);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    chk("after_pop_head", 32'(npc_out), 32'h4001);
    cyc(1'b1, 16'h2222, 16'h5001, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH + 1; k++)
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Illegal opcode still queued
    cyc(1'b1, 16'hF025, 16'h6000, 1'b0, 1'b0);
    chk("trap_illegal", 32'(illegal), 32'd1);
    chk("trap_ctrl", 32'({W_Control, E_Control, M_Control, wb_en}), 32'd0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Flush with two queued, concurrent push and pop offered
    cyc(1'b1, 16'h1283, 16'h7000, 1'b0, 1'b0);
    cyc(1'b1, 16'h5283, 16'h7001, 1'b0, 1'b0);
    cyc(1'b1, 16'hE0FF, 16'h7777, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 9) < 7), 16'($urandom),
          16'($urandom), 1'($urandom_range(0, 9) < 5),
          1'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-stream
    while (mq.size() < 2)
      cyc(1'b1, 16'h2005, 16'h7100 + 16'(mq.size()), 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    mq.delete();
    step();
    chk_zero("rst_held");
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 16'h1283, 16'h7200 + 16'(k), 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised LC3 decode stage that replaces the single-register enable-gated decode with a valid/ready decode queue. Each fetched instruction and its NPC are decoded at enqueue into the full LC3 control set: writeback, execute, memory, writeback-enable and illegal-opcode flag. They are buffered in a DEPTH-entry FIFO. The block sits between fetch (instruction memory output) and execute, and absorbs execute back-pressure without a combinational ready path to fetch.

## Interface
- DEPTH, 2: queue entries; power of two, ≥2.
- PC_W, 16: NPC width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous queue clear (branch redirect).
- in_valid  input  1  fetch presents Imem_dout/npc_in.
- in_ready  output  1  queue can accept.
- Imem_dout  input  16  instruction word.
- npc_in  input  PC_W  PC+1 of the instruction.
- out_valid  output  1  head entry valid.
- out_ready  input  1  execute accepts head.
- IR  output  16  head instruction.
- npc_out  output  PC_W  head NPC.
- W_Control  output  2  00 ALU, 01 memory load, 10 PC-relative (LEA).
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- M_Control  output  2  {store, indirect}.
- wb_en  output  1  instruction writes a register.
- illegal  output  1  opcode unsupported by this stage.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH) && rst high. Full queue deasserts in_ready even if a pop occurs in the same cycle; there is no pass-through.
- Decode happens at push. The stored entry is {IR, npc, W, E, M, wb_en, illegal}.
- Decode table (op = IR[15:12], i = IR[5]), given as W / E / M / wb_en:
  - ADD 0001: 00 / (i ? 000000 : 000001) / 00 / 1.
  - AND 0101: 00 / (i ? 010000 : 010001) / 00 / 1.
  - NOT 1001: 00 / 100000 / 00 / 1.
  - LD 0010: 01 / 000110 / 00 / 1.
  - LDR 0110: 01 / 001000 / 00 / 1.
  - LDI 1010: 01 / 000110 / 01 / 1.
  - LEA 1110: 10 / 000110 / 00 / 1.
  - ST 0011: 00 / 000110 / 10 / 0.
  - STR 0111: 00 / 001000 / 10 / 0.
  - STI 1011: 00 / 000110 / 11 / 0.
  - BR 0000: 00 / 000110 / 00 / 0.
  - JMP 1100: 00 / 001100 / 00 / 0.
  - JSR 0100, RTI 1000, 1101, TRAP 1111: all controls zero, wb_en 0, illegal 1. The entry is still queued.
- Outputs are driven from the head entry. They are valid only while out_valid=1 and are don't-care otherwise.
- count tracking:
  - Push only: +1.
  - Pop only: −1.
  - Simultaneous push and pop (only possible when not full): count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush has priority over push and pop. The next cycle has count=0 and out_valid=0. An input offered in the flush cycle is dropped, and the pop in that cycle does not occur.

## Timing
- Reset (rst low, asynchronous): count, pointers, all entries, every output and in_ready are 0. in_ready rises in the first clk after rst deasserts.
- Latency: a push at edge N into an empty queue gives out_valid=1 with decoded fields after edge N (one cycle).
- Throughput: one instruction per cycle while out_ready=1 and the queue is not full.
- Head outputs stay stable while out_valid && !out_ready.
- Reset mid-operation: the queue empties immediately and no entry survives.

## Structure
- Package lc3_pkg holds:
  - opcode localparams;
  - W_Control codes;
  - E_Control field positions and pcselect1 codes (00 offset11, 01 offset9, 10 offset6, 11 zero);
  - M_Control bit positions.
- Sub-module decode_ctrl: purely combinational, 16-bit IR in, {W, E, M, wb_en, illegal} out. decode_queue instantiates it at the push side.
- FIFO storage, pointers and count live in decode_queue.

## Test plan
- Reset, then push ADD 16'h1283 (i=0) with npc 16'h3001, out_ready=1 → next cycle out_valid=1, IR=1283, npc_out=3001, W=00, E=000001, M=00, wb_en=1.
- Stream LDI 16'hA405, STI 16'hB805, JMP 16'hC1C0, LDR 16'h6442 back-to-back → controls in order:
  - LDI: 01/000110/01;
  - STI: 00/000110/11;
  - JMP: 00/001100/00;
  - LDR: 01/001000/00;
  - one entry per cycle.
- With out_ready=0, push DEPTH entries → in_ready=0 after the DEPTH-th push and head held. Raise out_ready for one cycle → in_ready=1 next cycle and FIFO order preserved across pointer wrap.
- Push TRAP 16'hF025 → illegal=1, all controls 0, wb_en=0.
- With 2 entries queued, assert flush together with in_valid and out_ready → next cycle out_valid=0, count 0, offered word never appears.
- Assert rst low mid-stream between clock edges → outputs and in_ready drop to 0 immediately, without waiting for a clock edge.
